// File: rtl/rle_pkg.sv
// -----------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the RLE encoder/decoder pair: FSM state encoding,
// pair field positions inside a 16-bit half-word and packer lane geometry.
// A pair half-word is {byte[15:8], count[7:0]}; the low half of a 32-bit word
// is the earlier pair.
// -----------------------------------------------------------------------------
package rle_pkg;

   localparam int HALF_W        = 16;  // one {byte,count} pair
   localparam int LANE_W        = 8;   // one plaintext byte
   localparam int LANES         = 4;   // bytes per memory word
   localparam int WORD_W        = LANES * LANE_W;
   localparam int PAIR_BYTE_LSB = 8;
   localparam int PAIR_CNT_LSB  = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_CAP,
      S_EXPAND,
      S_WR,
      S_FLUSH
   } state_e;

   function automatic logic [LANE_W-1:0] pair_byte(input logic [HALF_W-1:0] half);
      return half[PAIR_BYTE_LSB +: LANE_W];
   endfunction

   function automatic logic [LANE_W-1:0] pair_cnt(input logic [HALF_W-1:0] half);
      return half[PAIR_CNT_LSB +: LANE_W];
   endfunction

   // Byte counter that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/rle_decode_low_area_if.sv
// -----------------------------------------------------------------------------
// rle_decode_low_area_if
// Start/done handshake plus dpsram port A of the RLE decoder.
//   start, rle_addr, rle_size, message_addr : job request (host -> decoder)
//   message_size, done                      : job result  (decoder -> host)
//   port_A_*                                : single-ported dpsram access
//   err                                     : only when RLE_DEC_ERRCHK_EN is defined
// Modports: master = host + memory side, slave = decoder.
// -----------------------------------------------------------------------------
interface rle_decode_low_area_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [31:0]       rle_addr;
   logic [31:0]       rle_size;
   logic [31:0]       message_addr;
   logic [31:0]       message_size;
   logic              done;
   logic              port_A_clk;
   logic [ADDR_W-1:0] port_A_addr;
   logic              port_A_we;
   logic [31:0]       port_A_data_in;
   logic [31:0]       port_A_data_out;
`ifdef RLE_DEC_ERRCHK_EN
   logic              err;
`endif

   modport master (
      output start, rle_addr, rle_size, message_addr, port_A_data_out,
      input  message_size, done, port_A_clk, port_A_addr, port_A_we, port_A_data_in
`ifdef RLE_DEC_ERRCHK_EN
      , input err
`endif
   );

   modport slave (
      input  start, rle_addr, rle_size, message_addr, port_A_data_out,
      output message_size, done, port_A_clk, port_A_addr, port_A_we, port_A_data_in
`ifdef RLE_DEC_ERRCHK_EN
      , output err
`endif
   );

endinterface

// File: rtl/rle_byte_packer.sv
// -----------------------------------------------------------------------------
// rle_byte_packer
// Collects decoded bytes into a 32-bit word, lane 0 first.
//   push_i   : append byte_i at the current lane
//   clear_i  : empty the packer (wins over push_i)
//   lane_o   : next lane to be written
//   full_o   : the next push completes the word
//   empty_o  : no bytes held
//   word_o   : held bytes, unused upper lanes read as 0
//   merged_o : word_o with byte_i placed at the current lane
// -----------------------------------------------------------------------------
module rle_byte_packer
   import rle_pkg::*;
(
   input  logic              clk,
   input  logic              nreset,
   input  logic              push_i,
   input  logic              clear_i,
   input  logic [LANE_W-1:0] byte_i,
   output logic [1:0]        lane_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [WORD_W-1:0] word_o,
   output logic [WORD_W-1:0] merged_o
);

   logic [1:0]        lane_q, lane_d;
   logic [WORD_W-1:0] word_q, word_d;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      merged_o                            = word_q;
      merged_o[lane_q*LANE_W +: LANE_W]   = byte_i;
      word_d                              = word_q;
      lane_d                              = lane_q;
      if (clear_i) begin
         word_d = '0;
         lane_d = '0;
      end else if (push_i) begin
         word_d = merged_o;
         lane_d = lane_q + 2'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         word_q <= '0;
         lane_q <= '0;
      end else begin
         word_q <= word_d;
         lane_q <= lane_d;
      end
   end

   assign lane_o  = lane_q;
   assign full_o  = (lane_q == 2'd3);
   assign empty_o = (lane_q == 2'd0);
   assign word_o  = word_q;

endmodule

// File: rtl/rle_decode_low_area.sv
// -----------------------------------------------------------------------------
// rle_decode_low_area
// Run-length decoder. Reads {byte,count} pairs from the dpsram over port A,
// expands each run one byte per cycle into a 4-byte packer and writes full
// words back to the message area. A trailing partial word is flushed with
// zero upper lanes. done rises in IDLE once the job is complete.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   bus         : rle_decode_low_area_if.slave (handshake + port A)
// Optional feature macro RLE_DEC_ERRCHK_EN: adds bus.err (sticky until the
// next start) for count-0 pairs and for output exceeding MAX_OUT_BYTES.
// -----------------------------------------------------------------------------
module rle_decode_low_area
   import rle_pkg::*;
#(
   parameter int ADDR_W = 16
`ifdef RLE_DEC_ERRCHK_EN
   , parameter int MAX_OUT_BYTES = 65535
`endif
) (
   input  logic                 clk,
   input  logic                 nreset,
   rle_decode_low_area_if.slave bus
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [30:0]         pairs_q, pairs_d;     // pairs not yet loaded
   logic [LANE_W-1:0]   run_q, run_d;         // bytes left in current run
   logic [LANE_W-1:0]   byte_q, byte_d;
   logic [HALF_W-1:0]   in_hi_q, in_hi_d;     // high pair of the fetched word
   logic                half_q, half_d;       // 1 = high pair already loaded
   logic [31:0]         msg_size_q, msg_size_d;
   logic                done_q, done_d;
   logic                we_q, we_d;
   logic [WORD_W-1:0]   data_in_q, data_in_d;
   logic                err_q, err_d;

   logic                pk_push, pk_clear, pk_full, pk_empty;
   logic [1:0]          pk_lane;
   logic [WORD_W-1:0]   pk_word, pk_merged;
   logic                go_end;

   rle_byte_packer u_packer (
      .clk      (clk),
      .nreset   (nreset),
      .push_i   (pk_push),
      .clear_i  (pk_clear),
      .byte_i   (byte_q),
      .lane_o   (pk_lane),
      .full_o   (pk_full),
      .empty_o  (pk_empty),
      .word_o   (pk_word),
      .merged_o (pk_merged)
   );

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      pairs_d    = pairs_q;
      run_d      = run_q;
      byte_d     = byte_q;
      in_hi_d    = in_hi_q;
      half_d     = half_q;
      msg_size_d = msg_size_q;
      done_d     = done_q;
      we_d       = 1'b0;
      data_in_d  = data_in_q;
      err_d      = err_q;
      pk_push    = 1'b0;
      pk_clear   = 1'b0;
      go_end     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               rd_addr_d  = bus.rle_addr[ADDR_W-1:0];
               wr_addr_d  = bus.message_addr[ADDR_W-1:0];
               pairs_d    = bus.rle_size[31:1];
               run_d      = '0;
               half_d     = 1'b0;
               msg_size_d = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               pk_clear   = 1'b1;
               // With no pairs the job ends through FLUSH without touching port A.
               state_d    = (bus.rle_size[31:1] == '0) ? S_FLUSH : S_RD_REQ;
            end
         end

         S_RD_REQ: state_d = S_RD_CAP;

         S_RD_CAP: begin
            rd_addr_d = rd_addr_q + ADDR_W'(4);
            in_hi_d   = bus.port_A_data_out[WORD_W-1:HALF_W];
            byte_d    = pair_byte(bus.port_A_data_out[HALF_W-1:0]);
            run_d     = pair_cnt(bus.port_A_data_out[HALF_W-1:0]);
            pairs_d   = pairs_q - 31'd1;
            half_d    = 1'b0;
`ifdef RLE_DEC_ERRCHK_EN
            if (pair_cnt(bus.port_A_data_out[HALF_W-1:0]) == '0) err_d = 1'b1;
`endif
            state_d   = S_EXPAND;
         end

         S_EXPAND: begin
            if (run_q != '0) begin
`ifdef RLE_DEC_ERRCHK_EN
               if (msg_size_q >= 32'(MAX_OUT_BYTES)) begin
                  err_d  = 1'b1;
                  go_end = 1'b1;
               end else
`endif
               begin
                  pk_push    = 1'b1;
                  run_d      = run_q - 8'd1;
                  msg_size_d = sat_inc(msg_size_q);
                  // The byte being pushed completes the word: write the merged
                  // value and restart the packer in the same cycle.
                  if (pk_full) begin
                     pk_clear  = 1'b1;
                     we_d      = 1'b1;
                     data_in_d = pk_merged;
                     state_d   = S_WR;
                  end
               end
            end else if (pairs_q == '0) begin
               go_end = 1'b1;
            end else if (!half_q) begin
               byte_d  = pair_byte(in_hi_q);
               run_d   = pair_cnt(in_hi_q);
               pairs_d = pairs_q - 31'd1;
               half_d  = 1'b1;
`ifdef RLE_DEC_ERRCHK_EN
               if (pair_cnt(in_hi_q) == '0) err_d = 1'b1;
`endif
            end else begin
               state_d = S_RD_REQ;
            end
         end

         S_WR: begin
            wr_addr_d = wr_addr_q + ADDR_W'(4);
            state_d   = S_EXPAND;
         end

         S_FLUSH: begin
            if (we_q) wr_addr_d = wr_addr_q + ADDR_W'(4);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (go_end) begin
         state_d = S_FLUSH;
         if (!pk_empty) begin
            we_d      = 1'b1;
            data_in_d = pk_word;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         pairs_q    <= '0;
         run_q      <= '0;
         byte_q     <= '0;
         in_hi_q    <= '0;
         half_q     <= 1'b0;
         msg_size_q <= '0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         data_in_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         pairs_q    <= pairs_d;
         run_q      <= run_d;
         byte_q     <= byte_d;
         in_hi_q    <= in_hi_d;
         half_q     <= half_d;
         msg_size_q <= msg_size_d;
         done_q     <= done_d;
         we_q       <= we_d;
         data_in_q  <= data_in_d;
         err_q      <= err_d;
      end
   end

   assign bus.port_A_clk     = clk;
   assign bus.port_A_addr    = we_q ? wr_addr_q : rd_addr_q;
   assign bus.port_A_we      = we_q;
   assign bus.port_A_data_in = data_in_q;
   assign bus.message_size   = msg_size_q;
   assign bus.done           = done_q;
`ifdef RLE_DEC_ERRCHK_EN
   assign bus.err            = err_q;
`endif

   // Address bits above the dpsram width, the ignored size LSB, the lane index
   // and (without error checking) the error flop have no consumer.
   logic unused_bits;
   assign unused_bits = ^{bus.rle_addr[31:ADDR_W], bus.message_addr[31:ADDR_W],
                          bus.rle_size[0], pk_lane, err_q};

endmodule
